fetch_ctrl: RTL

Instruction-fetch controller for Stage 1 (IF). Drives the PC register's `next_pc`/`PCWrite` inputs, issues single-outstanding requests to instruction memory over a req/ack handshake, and presents fetched instructions to the IF/ID boundary. Handles downstream stall through a one-entry skid buffer, and branch/jump redirect, including discarding a stale in-flight response.

---
 rtl/coa_defs.sv | 15 +
 rtl/fetch_skid.sv | 40 ++++
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/coa_defs.sv
// Shared fetch-stage definitions: controller state encoding, PC increment, NOP word.
// Constants only; no timing or flow-control behaviour of its own.
package coa_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instr/pc holding buffer for a fetch response that arrives while IF/ID is stalled.
// Load is visible the cycle after; flush and unload take priority over load.
module fetch_skid
    import coa_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_vld,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_vld;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld   <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= 32'h0;
        end else if (i_flush || i_unload) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld   <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_vld   = r_vld;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: single-outstanding imem req/ack, PC update, redirect with stale-response discard.
// Instruction valid one cycle after ack; a stalled full output slot parks one response in the skid and pauses fetch.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        PCWrite,
    output logic [31:0] next_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    import coa_defs::*;

    fetch_state_t r_state;
    logic         r_imem_req;
    logic [31:0]  r_imem_addr;
    logic         r_if_valid;
    logic [31:0]  r_if_instr;
    logic [31:0]  r_if_pc;

    logic         w_slot_free;
    logic         w_take_ack;
    logic         w_skid_load;
    logic         w_skid_unload;
    logic         w_skid_flush;
    logic         w_skid_vld;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc;
    logic [31:0]  w_addr_next;

    assign w_slot_free   = !r_if_valid || !stall;
    assign w_addr_next   = r_imem_addr + PC_STEP;
    assign w_take_ack    = (r_state == ST_REQ) && imem_ack && !redirect_valid;
    assign w_skid_load   = w_take_ack && !w_slot_free;
    assign w_skid_unload = (r_state == ST_HOLD) && w_skid_vld && !redirect_valid && !stall;
    assign w_skid_flush  = (r_state == ST_HOLD) && redirect_valid;

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_flush  (w_skid_flush),
        .i_instr  (imem_rdata),
        .i_pc     (r_imem_addr),
        .o_vld    (w_skid_vld),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    // Redirect wins over any ack; the PC only advances on a response that is actually kept.
    always_comb begin
        PCWrite = 1'b0;
        next_pc = pc_in;
        if (!reset) begin
            if (redirect_valid) begin
                PCWrite = 1'b1;
                next_pc = redirect_pc;
            end else if (w_take_ack) begin
                PCWrite = 1'b1;
                next_pc = w_addr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_instr  <= NOP_INSTR;
            r_if_pc     <= 32'h0;
        end else begin
            // A consumed or flushed output slot empties unless a state below refills it.
            if (redirect_valid || !stall) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!redirect_valid && w_slot_free) begin
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= pc_in;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        if (imem_ack) begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end else if (imem_ack) begin
                        if (w_slot_free) begin
                            r_if_valid  <= 1'b1;
                            r_if_instr  <= imem_rdata;
                            r_if_pc     <= r_imem_addr;
                            r_imem_addr <= w_addr_next;
                        end else begin
                            r_state    <= ST_HOLD;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_skid_unload) begin
                        r_state    <= ST_IDLE;
                        r_if_valid <= 1'b1;
                        r_if_instr <= w_skid_instr;
                        r_if_pc    <= w_skid_pc;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        r_state    <= ST_IDLE;
                        r_imem_req <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;

endmodule
